// File: rtl/pacman_dir_ctrl_if.sv
// Bundle between the board buttons, the move/maze block and the direction controller.
// The master drives buttons, move_tick and blocked; the slave returns direction state.
interface pacman_dir_ctrl_if;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       move_tick;
  logic [3:0] blocked;
  logic [1:0] dir;
  logic       moving;
  logic       pend_valid;
  logic [1:0] pend_dir;
  logic       turn_ack;

  modport master (
    output up, down, left, right, move_tick, blocked,
    input  dir, moving, pend_valid, pend_dir, turn_ack
  );

  modport slave (
    input  up, down, left, right, move_tick, blocked,
    output dir, moving, pend_valid, pend_dir, turn_ack
  );
endinterface

// File: rtl/pacman_dir_ctrl.sv
// PacMan direction controller: sync + debounce four buttons, buffer one turn request,
// and apply it to the player direction on move ticks when the maze allows it.
module pacman_dir_ctrl #(
  parameter int unsigned DB_COUNT   = 1000000,
  parameter int unsigned DB_W       = 20,
  parameter int unsigned PEND_TICKS = 8
) (
  input logic              clk,
  input logic              clr,
  pacman_dir_ctrl_if.slave bus
);

  localparam int unsigned       AGE_W   = $clog2(PEND_TICKS + 1);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_COUNT - 1);
  localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(PEND_TICKS);

  typedef enum logic {
    PEND_IDLE,
    PEND_HELD
  } pend_t;

  // Bit index equals the direction encoding: 0 up, 1 down, 2 left, 3 right.
  logic [3:0]      w_raw;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_db;
  logic [3:0]      r_db_prev;
  logic [3:0]      r_press;
  logic [DB_W-1:0] r_cnt [4];

  logic            w_any;
  logic [1:0]      w_win;

  pend_t           r_pstate;
  pend_t           w_pstate_n;
  logic [1:0]      r_pend_dir;
  logic [1:0]      w_pend_dir_n;
  logic [AGE_W-1:0] r_age;
  logic [AGE_W-1:0] w_age_n;
  logic [AGE_W-1:0] w_age_inc;
  logic [1:0]      r_dir;
  logic [1:0]      w_dir_n;
  logic            r_moving;
  logic            w_moving_n;
  logic            r_ack;
  logic            w_ack_n;

  assign w_raw = {bus.right, bus.left, bus.down, bus.up};

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      r_press   <= '0;
      for (int unsigned b = 0; b < 4; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      // Rising-edge pulse is registered so the arbiter sees a clean one-cycle strobe.
      r_press   <= r_db & ~r_db_prev;
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_sync2[b] == r_db[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == DB_LAST) begin
          r_db[b]  <= r_sync2[b];
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_any = |r_press;
    w_win = 2'b11;
    if (r_press[0]) begin
      w_win = 2'b00;
    end else if (r_press[1]) begin
      w_win = 2'b01;
    end else if (r_press[2]) begin
      w_win = 2'b10;
    end
  end

  assign w_age_inc = r_age + AGE_W'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_pstate   <= PEND_IDLE;
      r_pend_dir <= 2'b00;
      r_age      <= '0;
      r_dir      <= 2'b10;
      r_moving   <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_pstate   <= w_pstate_n;
      r_pend_dir <= w_pend_dir_n;
      r_age      <= w_age_n;
      r_dir      <= w_dir_n;
      r_moving   <= w_moving_n;
      r_ack      <= w_ack_n;
    end
  end

  // Tick resolves against the pre-tick pending state; a same-cycle press then overrides it.
  always_comb begin
    w_pstate_n   = r_pstate;
    w_pend_dir_n = r_pend_dir;
    w_age_n      = r_age;
    w_dir_n      = r_dir;
    w_moving_n   = r_moving;
    w_ack_n      = 1'b0;

    if (bus.move_tick) begin
      if ((r_pstate == PEND_HELD) && !bus.blocked[r_pend_dir]) begin
        w_dir_n    = r_pend_dir;
        w_moving_n = 1'b1;
        w_pstate_n = PEND_IDLE;
        w_ack_n    = 1'b1;
      end else begin
        w_moving_n = !bus.blocked[r_dir];
        if (r_pstate == PEND_HELD) begin
          if (r_age != AGE_MAX) begin
            w_age_n = w_age_inc;
          end
          if (w_age_inc == AGE_MAX) begin
            w_pstate_n = PEND_IDLE;
          end
        end
      end
    end

    if (w_any) begin
      w_pstate_n   = PEND_HELD;
      w_pend_dir_n = w_win;
      w_age_n      = '0;
    end
  end

  assign bus.dir        = r_dir;
  assign bus.moving     = r_moving;
  assign bus.pend_valid = (r_pstate == PEND_HELD);
  assign bus.pend_dir   = r_pend_dir;
  assign bus.turn_ack   = r_ack;

endmodule
